// File: rtl/sram_write_queue.sv
// sram_write_queue: FIFO of SRAM write requests, each presented to the controller for a fixed 5-cycle slot
// (4 cycles with wr_en high, then one hold cycle) so every entry lands exactly once whatever the controller phase.
module sram_write_queue #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic                     clk_100m,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, HOLD, TAIL} state_t;
   state_t             r_state, w_next;
   logic [1:0]         r_cnt;
   logic [PW-1:0]      r_wptr, r_rptr;
   logic [PW:0]        r_count;
   logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
   logic [DATA_W-1:0]  r_mem_data [DEPTH];
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [DATA_W-1:0]  r_wr_data;
   logic               w_push, w_pop;
   assign in_ready = r_count != (PW+1)'(DEPTH);
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_count != '0) && (r_state != HOLD);
   assign wr_en    = r_state == HOLD;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign level    = r_count;
   assign busy     = (r_state != IDLE) || (r_count != '0);
   always_comb begin
      w_next = r_state;
      if (r_state == HOLD) w_next = (r_cnt == 2'd3) ? TAIL : HOLD;
      else w_next = w_pop ? HOLD : IDLE;
   end
   // Storage carries no reset: entries are only ever read behind a valid count.
   always_ff @(posedge clk_100m) begin
      if (w_push) begin
         r_mem_addr[r_wptr] <= in_addr;
         r_mem_data[r_wptr] <= in_data;
      end
   end
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 2'd0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == HOLD) ? r_cnt + 2'd1 : 2'd0;
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop) begin
            r_rptr    <= r_rptr + PW'(1);
            r_wr_addr <= r_mem_addr[r_rptr];
            r_wr_data <= r_mem_data[r_rptr];
         end
      end
   end
endmodule

// File: tb/tb_sram_write_queue.sv
// tb_sram_write_queue: random and directed stimulus against a slot-timer/queue reference model,
// plus a free-running 4-phase controller model that logs sampled writes.
module tb_sram_write_queue;
   localparam int DEPTH = 16, AW = 20, DW = 32;
   logic            clk_100m = 0, rst_n = 0, in_valid = 0;
   logic [AW-1:0]   in_addr = '0;
   logic [DW-1:0]   in_data = '0;
   logic            in_ready, wr_en, busy;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [4:0]      level;
   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
   ent_t q[$], plog[$], wlog[$];
   ent_t cur;
   int   t, phase, dut_acc, n_tests = 0, n_fail = 0;

   sram_write_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_100m(clk_100m), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .level(level), .busy(busy));

   always #5 clk_100m = ~clk_100m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ent_t rnd_ent();
      return ent_t'{a: AW'($urandom), d: $urandom};
   endfunction

   // One clock: drive, let the edge happen, advance the model, compare at the falling edge.
   task automatic cycle(input logic v, input ent_t e);
      bit push, pop;
      in_valid = v; in_addr = e.a; in_data = e.d;
      #1;
      if (v && in_ready) dut_acc++;
      @(posedge clk_100m);
      push = v && q.size() < DEPTH;
      pop  = q.size() != 0 && (t == 0 || t == 5);
      if (pop) begin cur = q.pop_front(); t = 1; end
      else if (t >= 1 && t <= 4) t++;
      else t = 0;
      if (push) begin q.push_back(e); plog.push_back(e); end
      @(negedge clk_100m);
      check("wr_en", 64'(wr_en), 64'(t >= 1 && t <= 4));
      check("wr_addr", 64'(wr_addr), 64'(cur.a));
      check("wr_data", 64'(wr_data), 64'(cur.d));
      check("level", 64'(level), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("busy", 64'(busy), 64'(t != 0 || q.size() != 0));
      if (wr_en && phase == 0) wlog.push_back(ent_t'{a: wr_addr, d: wr_data});
      phase = (phase + 1) % 4;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      check({tag, "_wr_data"}, 64'(wr_data), 64'(0));
      check({tag, "_level"}, 64'(level), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
   endtask

   task automatic do_reset(input int ph);
      in_valid = 0; rst_n = 0;
      q.delete(); cur = '0; t = 0;
      #2 check_reset_outputs("reset");
      @(negedge clk_100m);
      rst_n = 1; phase = ph;
   endtask

   initial begin
      int guard;
      ent_t e;
      dut_acc = 0; phase = 0; t = 0; cur = '0;
      #3 do_reset(0);
      // single write from idle
      cycle(1, ent_t'{a: 20'h00010, d: 32'hDEADBEEF});
      for (int i = 0; i < 8; i++) cycle(0, '0);
      // burst of DEPTH+2 with in_valid held: backpressure and full-plus-pop edges
      dut_acc = 0; guard = 0;
      while (dut_acc < DEPTH + 2 && guard < 300) begin
         cycle(1, ent_t'{a: AW'(dut_acc + 32'h100), d: 32'hA5000000 + dut_acc});
         guard++;
      end
      check("burst_accepted", 64'(dut_acc), 64'(DEPTH + 2));
      guard = 0;
      while (busy && guard < 200) begin cycle(0, '0); guard++; end
      check("burst_drained", 64'(busy), 64'(0));
      // phase independence against the 4-phase controller model
      for (int ph = 0; ph < 4; ph++) begin
         do_reset(ph);
         wlog.delete(); plog.delete();
         guard = 0;
         while (plog.size() < 8 && guard < 200) begin
            cycle(($urandom_range(0, 2) == 0), rnd_ent());
            guard++;
         end
         for (int i = 0; i < 60; i++) cycle(0, '0);
         check("phase_writes", 64'(wlog.size()), 64'(8));
         for (int i = 0; i < 8 && i < wlog.size(); i++) check("phase_entry", 64'(wlog[i]), 64'(plog[i]));
      end
      // random traffic faster than drain rate, so full and simultaneous push/pop occur
      for (int i = 0; i < 400; i++) cycle(($urandom_range(0, 2) == 0), rnd_ent());
      // reset during HOLD count 2 with 5 entries queued
      do_reset(0);
      guard = 0;
      while (!(t == 3 && q.size() == 5) && guard < 100) begin
         cycle(q.size() < 5, rnd_ent());
         guard++;
      end
      check("midslot_reached", 64'(t == 3 && q.size() == 5), 64'(1));
      rst_n = 0;
      #1 check_reset_outputs("midslot");
      q.delete(); cur = '0; t = 0;
      @(negedge clk_100m);
      rst_n = 1;
      for (int i = 0; i < 10; i++) cycle(0, '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
